// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The master side belongs to the fetch unit. It drives the memory read
// request and presents the instruction register to decode.
interface instr_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 19
);
  // instruction-memory read channel
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  // decode handshake
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output mem_rd_en, mem_addr, ir_out, ir_valid,
    input  mem_rd_data, mem_rd_valid, ir_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, ir_out, ir_valid,
    output mem_rd_data, mem_rd_valid, ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. It issues a single-beat read at the PC and
// captures the returned word into the instruction register. The word is
// handed to decode with valid/ready, and each capture pulses pc_inc so the
// PC can advance. A fetch that gets no response within TIMEOUT wait cycles
// raises a sticky error. Only flush or reset clear that error.
module instr_fetch_unit #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 19,
  parameter int TIMEOUT = 15   // legal range 1..255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_req,
  input  logic              flush,
  instr_fetch_if.master     bus,
  output logic              pc_inc,
  output logic              fetch_busy,
  output logic              fetch_err
);

  // Counter sized to hold TIMEOUT; it saturates at its terminal value.
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              launch;     // a new read is being started this cycle
  logic              capture;    // mem_rd_data is being taken into the IR

  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] ir_out_q;
  logic              ir_valid_q;
  logic              pc_inc_q;
  logic              fetch_busy_q;
  logic              fetch_err_q;

  // Next-state decode. Flush overrides every state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (which would infer a latch).
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // mem_rd_valid is ignored here, which drops late responses after a flush
          if (fetch_req) begin
            launch  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_rd_valid) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rd_valid) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end else if (wait_cnt_q == CNT_LAST) begin
            state_d = S_ERR;
          end
        end
        S_HOLD: begin
          // A new fetch starts only once decode has taken the current word.
          if (bus.ir_ready) begin
            if (fetch_req) begin
              launch  = 1'b1;
              state_d = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register and registered control outputs derived from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      mem_rd_en_q  <= 1'b0;
      ir_valid_q   <= 1'b0;
      pc_inc_q     <= 1'b0;
      fetch_busy_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      mem_rd_en_q  <= launch;
      ir_valid_q   <= (state_d == S_HOLD);
      pc_inc_q     <= capture;
      fetch_busy_q <= (state_d != S_IDLE);
      if (flush) begin
        fetch_err_q <= 1'b0;
      end else if (state_d == S_ERR) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  // Address and instruction registers, loaded only on launch or capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: these datapath registers are reset because they are visible outputs that must read 0 out of reset.
      mem_addr_q <= '0;
      ir_out_q   <= '0;
    end else begin
      if (launch) begin
        mem_addr_q <= pc_addr;
      end
      if (capture) begin
        ir_out_q <= bus.mem_rd_data;
      end
    end
  end

  // Wait-cycle counter. It clears in REQ and counts up in WAIT without wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_REQ) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT && wait_cnt_q != CNT_LAST) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ir_out    = ir_out_q;
  assign bus.ir_valid  = ir_valid_q;
  assign pc_inc        = pc_inc_q;
  assign fetch_busy    = fetch_busy_q;
  assign fetch_err     = fetch_err_q;

endmodule
